pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 8, SHALL set the program-counter and target width.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-address stack entries, with a minimum of 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 ce  input  1  SHALL be the step enable; when low, all state holds.
REQ-006 op  input  3  SHALL be the operation, of type op_t: NEXT, JMP, JCC, CALL, RET, HALT; other encodings SHALL be treated as NEXT.
REQ-007 cond  input  3  SHALL be the JCC condition, of type cond_t: Z, NZ, C, NC, S, NS, OV, NOV.
REQ-008 target  input  PC_W  SHALL be the jump or call destination.
REQ-009 cy, ov, zf, sf  input  1 each  SHALL be the carry, overflow, zero and sign flags, sampled when ce is high.
REQ-010 pc  output  PC_W  SHALL be the registered program counter.
REQ-011 taken  output  1  SHALL be a registered one-step pulse indicating that the last step redirected pc.
REQ-012 halted  output  1  SHALL be the registered HALT state indicator.
REQ-013 stack_err  output  1  SHALL be a sticky stack overflow or underflow flag.
REQ-014 depth  output  $clog2(STACK_DEPTH+1)  SHALL give the current stack occupancy.

Function
REQ-015 The state machine SHALL have two states, RUN and HALTED; HALTED SHALL be left only by reset.
REQ-016 In RUN with ce=1, the next pc SHALL be one of:
- NEXT: pc+1.
- JMP: target.
- JCC: target if the condition holds, else pc+1.
- CALL: push pc+1, then target.
- RET: pop value.
- HALT: pc unchanged, then go to HALTED.
REQ-017 pc+1 SHALL wrap modulo 2^PC_W; pushed return addresses SHALL wrap the same way (for example, 8'hFF gives 8'h00).
REQ-018 Condition truth SHALL be: Z=zf, NZ=!zf, C=cy, NC=!cy, S=sf, NS=!sf, OV=ov, NOV=!ov.
REQ-019 taken SHALL be 1 in the cycle after a step that loaded target or a popped value, and 0 otherwise, including when ce=0.
REQ-020 Latency SHALL be exactly one clock from the ce=1 edge to the updated pc, taken and depth.
REQ-021 CALL with depth==STACK_DEPTH SHALL set stack_err, SHALL NOT push, SHALL advance pc to pc+1, and SHALL leave taken=0.
REQ-022 RET with depth==0 SHALL set stack_err, SHALL advance pc to pc+1, and SHALL leave taken=0.
REQ-023 Once set, stack_err SHALL remain set until reset.
REQ-024 In HALTED, pc, the stack and depth SHALL hold regardless of ce and op, and taken SHALL be 0.
REQ-025 The stack SHALL be LIFO; a CALL followed by a RET SHALL return to the address after the CALL.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL set pc=0, depth=0, taken=0, stack_err=0, halted=0 and state=RUN, overriding ce and op.
REQ-027 Reset mid-sequence SHALL discard all stack contents; stack RAM contents need not be cleared, but SHALL be unreachable.

Structure
REQ-028 Package pc_seq_pkg SHALL hold op_t, cond_t, the state enum and the default PC_W and STACK_DEPTH constants.
REQ-029 Sub-module ret_stack SHALL implement the LIFO with push, pop, full, empty and depth outputs, and SHALL ignore a push when full and a pop when empty.
REQ-030 Condition evaluation SHALL be a function in pc_seq_pkg and SHALL NOT be a separate module.

Verification
REQ-031 Reset, then 3 NEXT steps -> pc=0,1,2,3; taken=0 throughout.
REQ-032 pc=0x10, zf=1: JCC Z target=0x40 -> pc=0x40, taken=1; next JCC NZ target=0x80 -> pc=0x41, taken=0.
REQ-033 CALL to 0x20 at pc=0x05, CALL to 0x30, RET, RET -> pc sequence 0x20, 0x30, 0x21, 0x06; depth 1, 2, 1, 0.
REQ-034 With STACK_DEPTH=4, 5 CALLs -> 5th leaves depth=4, sets stack_err=1 and gives pc=previous+1; RET with empty stack after reset -> stack_err=1, pc=1.
REQ-035 pc=0xFF, NEXT -> pc=0x00; CALL at 0xFF -> pushed 0x00, which RET returns.
REQ-036 HALT at pc=0x07 -> halted=1 and pc stays 0x07 under ce=1 with JMP; ce=0 mid-run holds all state; rst_n=0 restores pc=0 and halted=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types, default sizes and the branch-condition evaluator for the PC sequencer.
package pc_seq_pkg;

  localparam int unsigned DEF_PC_W        = 8;
  localparam int unsigned DEF_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_JCC  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    C_Z   = 3'd0,
    C_NZ  = 3'd1,
    C_C   = 3'd2,
    C_NC  = 3'd3,
    C_S   = 3'd4,
    C_NS  = 3'd5,
    C_OV  = 3'd6,
    C_NOV = 3'd7
  } cond_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Truth of a JCC condition for the given flag set.
  function automatic logic cond_true(input cond_t c, input logic cy, input logic ov,
                                     input logic zf, input logic sf);
    logic r;
    r = 1'b0;
    case (c)
      C_Z:     r = zf;
      C_NZ:    r = ~zf;
      C_C:     r = cy;
      C_NC:    r = ~cy;
      C_S:     r = sf;
      C_NS:    r = ~sf;
      C_OV:    r = ov;
      C_NOV:   r = ~ov;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; pushes when full and pops when empty are dropped.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  top_c,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] depth
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;
  logic [AW-1:0] wr_idx, top_idx;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q & ~do_push;
  assign wr_idx  = AW'(cnt_q);
  assign top_idx = empty_q ? '0 : AW'(cnt_q - CW'(1));

  // Next occupancy from the accepted push/pop.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);
  end

  // Occupancy and registered full/empty; reset empties the stack logically.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Entry storage; contents survive reset but become unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

  assign top_c = mem[top_idx];
  assign full  = full_q;
  assign empty = empty_q;
  assign depth = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with conditional jumps, call/return stack and halt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  op_t             op,
  input  cond_t           cond,
  input  logic [PC_W-1:0] target,
  input  logic            cy,
  input  logic            ov,
  input  logic            zf,
  input  logic            sf,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic            halted,
  output logic            stack_err,
  output logic [DW-1:0]   depth
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            err_q, err_d;
  logic            halted_q;
  logic            push_c, pop_c;
  logic [PC_W-1:0] pc_inc_c;
  logic [PC_W-1:0] ret_addr_c;
  logic            stk_full, stk_empty;

  assign pc_inc_c = pc_q + PC_W'(1);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (pc_inc_c),
    .top_c (ret_addr_c),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (depth)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state, next pc and stack control for one step.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    err_d   = err_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    if (state_q == ST_RUN && ce) begin
      case (op)
        OP_JMP: begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_JCC: begin
          if (cond_true(cond, cy, ov, zf, sf)) begin
            pc_d    = target;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc_c;
          end
        end
        OP_CALL: begin
          if (stk_full) begin
            err_d = 1'b1;
            pc_d  = pc_inc_c;
          end else begin
            push_c  = 1'b1;
            pc_d    = target;
            taken_d = 1'b1;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            err_d = 1'b1;
            pc_d  = pc_inc_c;
          end else begin
            pop_c   = 1'b1;
            pc_d    = ret_addr_c;
            taken_d = 1'b1;
          end
        end
        OP_HALT: state_d = ST_HALTED;
        default: pc_d = pc_inc_c;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= '0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      taken_q  <= taken_d;
      err_q    <= err_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign stack_err = err_q;
  assign halted    = halted_q;

endmodule
